// File: rtl/l1_mem_arbiter.sv
// Arbitrates the shared memory/L2 port between icache refills (requester 0) and
// dcache refills/writebacks (requester 1), one transaction outstanding at a time.
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid_i,
    output logic                  ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
    input  logic                  ic_kill_i,
    output logic                  ic_resp_valid_o,
    input  logic                  ic_resp_ready_i,
    output logic [LINE_WIDTH-1:0] ic_resp_data_o,

    input  logic                  dc_req_valid_i,
    output logic                  dc_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
    input  logic                  dc_req_we_i,
    input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
    output logic                  dc_resp_valid_o,
    input  logic                  dc_resp_ready_i,
    output logic [LINE_WIDTH-1:0] dc_resp_data_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic                  mem_req_we_o,
    output logic [LINE_WIDTH-1:0] mem_req_wdata_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [LINE_WIDTH-1:0] mem_resp_data_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic                  rr_last_reg, rr_last_next;
    logic                  killed_reg, killed_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;

    logic                  ic_eligible;
    logic                  grant_ic;
    logic                  grant_dc;
    logic                  ic_kill_owned;
    logic                  wait_kill;
    logic [1:0]            resp_ready_vec;
    logic [1:0]            resp_valid_vec;
    logic [LINE_WIDTH-1:0] resp_data_vec [2];

    // A killed icache request in the same cycle never wins; rr_last=1 favours icache.
    assign ic_eligible   = ic_req_valid_i && !ic_kill_i;
    assign grant_ic      = (state_reg == IDLE) && !reset && ic_eligible
                           && (!dc_req_valid_i || rr_last_reg);
    assign grant_dc      = (state_reg == IDLE) && !reset && dc_req_valid_i
                           && (!ic_eligible || !rr_last_reg);
    assign ic_kill_owned = ic_kill_i && !owner_reg;
    assign wait_kill     = (state_reg == WAIT) && ic_kill_owned;

    assign resp_ready_vec = {dc_resp_ready_i, ic_resp_ready_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign resp_valid_vec[gi] = (state_reg == WAIT) && (owner_reg == 1'(gi))
                                        && mem_resp_valid_i && !wait_kill;
            assign resp_data_vec[gi]  = ((state_reg == WAIT) && (owner_reg == 1'(gi)))
                                        ? mem_resp_data_i : '0;
        end
    endgenerate

    assign ic_req_ready_o  = grant_ic;
    assign dc_req_ready_o  = grant_dc;
    assign ic_resp_valid_o = resp_valid_vec[0];
    assign dc_resp_valid_o = resp_valid_vec[1];
    assign ic_resp_data_o  = resp_data_vec[0];
    assign dc_resp_data_o  = resp_data_vec[1];

    assign mem_req_valid_o = (state_reg == REQ);
    assign mem_req_addr_o  = addr_reg;
    assign mem_req_we_o    = we_reg;
    assign mem_req_wdata_o = wdata_reg;

    // In the kill cycle the response is left pending so DRAIN is the one that swallows it.
    always_comb begin
        mem_resp_ready_o = 1'b0;
        if (state_reg == WAIT) begin
            mem_resp_ready_o = !wait_kill && resp_ready_vec[owner_reg];
        end else if (state_reg == DRAIN) begin
            mem_resp_ready_o = 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_last_next = rr_last_reg;
        killed_next  = killed_reg;
        addr_next    = addr_reg;
        we_next      = we_reg;
        wdata_next   = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_ic) begin
                    owner_next   = 1'b0;
                    rr_last_next = 1'b0;
                    killed_next  = 1'b0;
                    addr_next    = ic_req_addr_i;
                    we_next      = 1'b0;
                    wdata_next   = '0;
                    state_next   = REQ;
                end else if (grant_dc) begin
                    owner_next   = 1'b1;
                    rr_last_next = 1'b1;
                    killed_next  = 1'b0;
                    addr_next    = dc_req_addr_i;
                    we_next      = dc_req_we_i;
                    wdata_next   = dc_req_wdata_i;
                    state_next   = REQ;
                end
            end
            REQ: begin
                killed_next = killed_reg || ic_kill_owned;
                if (mem_req_ready_i) begin
                    state_next = (killed_reg || ic_kill_owned) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (wait_kill) begin
                    state_next = DRAIN;
                end else if (mem_resp_valid_i && mem_resp_ready_o) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (mem_resp_valid_i) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
            killed_reg  <= 1'b0;
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_last_reg <= rr_last_next;
            killed_reg  <= killed_next;
            addr_reg    <= addr_next;
            we_reg      <= we_next;
            wdata_reg   <= wdata_next;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: a transaction-phase model checked every cycle,
// plus literal expectations for each scenario.
module tb_l1_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    localparam logic [LW-1:0] D1   = {8{32'h1C00_0001}};
    localparam logic [LW-1:0] D2   = {8{32'hDC00_0002}};
    localparam logic [LW-1:0] D3   = {8{32'hAC00_0003}};
    localparam logic [LW-1:0] WA5  = {32{8'hA5}};
    localparam logic [LW-1:0] D7   = {8{32'hDC00_0007}};
    localparam logic [LW-1:0] DEAD = {16{16'hDEAD}};
    localparam logic [LW-1:0] D5   = {8{32'hDC00_0005}};
    localparam logic [LW-1:0] D6   = {8{32'h1C00_0006}};
    localparam logic [LW-1:0] D8   = {8{32'hDC00_0008}};
    localparam logic [LW-1:0] D9   = {8{32'h1C00_0009}};
    localparam logic [LW-1:0] DA   = {8{32'h1C00_000A}};
    localparam logic [LW-1:0] DB   = {8{32'hDC00_000B}};

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid_i, ic_req_ready_o, ic_kill_i;
    logic [AW-1:0] ic_req_addr_i;
    logic          ic_resp_valid_o, ic_resp_ready_i;
    logic [LW-1:0] ic_resp_data_o;
    logic          dc_req_valid_i, dc_req_ready_o, dc_req_we_i;
    logic [AW-1:0] dc_req_addr_i;
    logic [LW-1:0] dc_req_wdata_i;
    logic          dc_resp_valid_o, dc_resp_ready_i;
    logic [LW-1:0] dc_resp_data_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [LW-1:0] mem_req_wdata_o;
    logic          mem_resp_valid_i, mem_resp_ready_o;
    logic [LW-1:0] mem_resp_data_i;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_req_addr_i(ic_req_addr_i), .ic_kill_i(ic_kill_i),
        .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_ready_i(ic_resp_ready_i),
        .ic_resp_data_o(ic_resp_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_we_i(dc_req_we_i),
        .dc_req_wdata_i(dc_req_wdata_i),
        .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_ready_i(dc_resp_ready_i),
        .dc_resp_data_o(dc_resp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_wdata_o(mem_req_wdata_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_data_i(mem_resp_data_i)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Transaction-phase model: busy from grant until the response is consumed or dropped.
    logic          m_busy, m_issued, m_cancel, m_owner, m_rr, m_we;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          ic_elig, kill_now;
    logic          exp_ic_ready, exp_dc_ready, exp_mreq_valid;
    logic          exp_mresp_ready, exp_ic_rvalid, exp_dc_rvalid;

    always_comb begin
        ic_elig         = ic_req_valid_i && !ic_kill_i;
        exp_ic_ready    = !reset && !m_busy && ic_elig && (!dc_req_valid_i || m_rr);
        exp_dc_ready    = !reset && !m_busy && dc_req_valid_i && !(ic_elig && m_rr);
        exp_mreq_valid  = m_busy && !m_issued;
        kill_now        = ic_kill_i && !m_owner;
        exp_mresp_ready = 1'b0;
        exp_ic_rvalid   = 1'b0;
        exp_dc_rvalid   = 1'b0;
        if (m_busy && m_issued) begin
            if (m_cancel)      exp_mresp_ready = 1'b1;
            else if (kill_now) exp_mresp_ready = 1'b0;
            else               exp_mresp_ready = m_owner ? dc_resp_ready_i : ic_resp_ready_i;
            exp_ic_rvalid = !m_owner && !m_cancel && !kill_now && mem_resp_valid_i;
            exp_dc_rvalid = m_owner && mem_resp_valid_i;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_issued <= 1'b0; m_cancel <= 1'b0; m_rr <= 1'b1;
            m_owner <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
        end else if (exp_ic_ready) begin
            m_busy <= 1'b1; m_issued <= 1'b0; m_cancel <= 1'b0;
            m_owner <= 1'b0; m_rr <= 1'b0; m_addr <= ic_req_addr_i; m_we <= 1'b0; m_wdata <= '0;
        end else if (exp_dc_ready) begin
            m_busy <= 1'b1; m_issued <= 1'b0; m_cancel <= 1'b0;
            m_owner <= 1'b1; m_rr <= 1'b1; m_addr <= dc_req_addr_i;
            m_we <= dc_req_we_i; m_wdata <= dc_req_wdata_i;
        end else if (m_busy) begin
            if (kill_now) m_cancel <= 1'b1;
            if (!m_issued && mem_req_ready_i) m_issued <= 1'b1;
            if (m_issued && mem_resp_valid_i && exp_mresp_ready) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ic_req_ready", LW'(ic_req_ready_o), LW'(exp_ic_ready));
            chk("dc_req_ready", LW'(dc_req_ready_o), LW'(exp_dc_ready));
            chk("mem_req_valid", LW'(mem_req_valid_o), LW'(exp_mreq_valid));
            chk("mem_resp_ready", LW'(mem_resp_ready_o), LW'(exp_mresp_ready));
            chk("ic_resp_valid", LW'(ic_resp_valid_o), LW'(exp_ic_rvalid));
            chk("dc_resp_valid", LW'(dc_resp_valid_o), LW'(exp_dc_rvalid));
            if (exp_mreq_valid) begin
                chk("mem_req_addr", LW'(mem_req_addr_o), LW'(m_addr));
                chk("mem_req_we", LW'(mem_req_we_o), LW'(m_we));
                if (m_we) chk("mem_req_wdata", mem_req_wdata_o, m_wdata);
            end
            if (exp_ic_rvalid) chk("ic_resp_data", ic_resp_data_o, mem_resp_data_i);
            if (exp_dc_rvalid) chk("dc_resp_data", dc_resp_data_o, mem_resp_data_i);
        end
    end

    // Transaction log and capture for literal checks.
    logic [AW-1:0] addr_q [$];
    logic          we_q   [$];
    logic [LW-1:0] wd_q   [$];
    int            ic_cnt = 0;
    int            dc_cnt = 0;
    logic [LW-1:0] ic_last = '0;
    logic [LW-1:0] dc_last = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                addr_q.push_back(mem_req_addr_o);
                we_q.push_back(mem_req_we_o);
                wd_q.push_back(mem_req_wdata_o);
                $display("txn mem_req addr=%h we=%b", mem_req_addr_o, mem_req_we_o);
            end
            if (ic_resp_valid_o && ic_resp_ready_i) begin
                ic_cnt++; ic_last = ic_resp_data_o;
                $display("txn ic_resp data=%h", ic_resp_data_o);
            end
            if (dc_resp_valid_o && dc_resp_ready_i) begin
                dc_cnt++; dc_last = dc_resp_data_o;
                $display("txn dc_resp data=%h", dc_resp_data_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ic_send(input logic [AW-1:0] a);
        bit got = 1'b0;
        ic_req_valid_i = 1'b1; ic_req_addr_i = a;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ic_req_ready_o) got = 1'b1;
        end
        if (!got) chk("ic_grant_timeout", LW'(0), LW'(1));
        @(posedge clk); #1;
        ic_req_valid_i = 1'b0;
    endtask

    task automatic dc_send(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] wd);
        bit got = 1'b0;
        dc_req_valid_i = 1'b1; dc_req_addr_i = a; dc_req_we_i = we; dc_req_wdata_i = wd;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (dc_req_ready_o) got = 1'b1;
        end
        if (!got) chk("dc_grant_timeout", LW'(0), LW'(1));
        @(posedge clk); #1;
        dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0; dc_req_wdata_i = '0;
    endtask

    task automatic wait_req_hs();
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i) got = 1'b1;
        end
        if (!got) chk("mem_req_timeout", LW'(0), LW'(1));
        @(posedge clk); #1;
    endtask

    task automatic give_resp(input logic [LW-1:0] d);
        bit got = 1'b0;
        mem_resp_valid_i = 1'b1; mem_resp_data_i = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (mem_resp_ready_o) got = 1'b1;
        end
        if (!got) chk("mem_resp_timeout", LW'(0), LW'(1));
        @(posedge clk); #1;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    endtask

    task automatic mem_serve(input logic [LW-1:0] d, input int lat);
        wait_req_hs();
        repeat (lat) tick();
        give_resp(d);
    endtask

    initial begin
        int b;
        int nic;
        int ndc;
        reset = 1'b1;
        ic_req_valid_i = 1'b0; ic_req_addr_i = '0; ic_kill_i = 1'b0; ic_resp_ready_i = 1'b1;
        dc_req_valid_i = 1'b0; dc_req_addr_i = '0; dc_req_we_i = 1'b0; dc_req_wdata_i = '0;
        dc_resp_ready_i = 1'b1; mem_req_ready_i = 1'b1;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1: contention after reset, icache first
        fork
            ic_send(32'h1000);
            dc_send(32'h2000, 1'b0, '0);
            begin mem_serve(D1, 0); mem_serve(D2, 0); end
        join
        chk("t1_first_addr", LW'(addr_q[0]), LW'(32'h1000));
        chk("t1_second_addr", LW'(addr_q[1]), LW'(32'h2000));
        chk("t1_ic_count", LW'(ic_cnt), LW'(1));
        chk("t1_ic_data", ic_last, D1);
        chk("t1_dc_count", LW'(dc_cnt), LW'(1));
        chk("t1_dc_data", dc_last, D2);

        // 2: dcache writeback with a stalled memory port
        b = addr_q.size(); ndc = dc_cnt;
        mem_req_ready_i = 1'b0;
        fork
            dc_send(32'h3000, 1'b1, WA5);
            begin repeat (4) tick(); mem_req_ready_i = 1'b1; mem_serve(D3, 0); end
        join
        chk("t2_addr", LW'(addr_q[b]), LW'(32'h3000));
        chk("t2_we", LW'(we_q[b]), LW'(1));
        chk("t2_wdata", wd_q[b], WA5);
        chk("t2_dc_ack_count", LW'(dc_cnt), LW'(ndc + 1));

        // 7: icache request killed in its own cycle loses to dcache
        b = addr_q.size();
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h3F00; ic_kill_i = 1'b1;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h3100; dc_req_we_i = 1'b0;
        @(negedge clk);
        chk("t7_ic_ready", LW'(ic_req_ready_o), LW'(0));
        chk("t7_dc_ready", LW'(dc_req_ready_o), LW'(1));
        @(posedge clk); #1;
        ic_req_valid_i = 1'b0; ic_kill_i = 1'b0; dc_req_valid_i = 1'b0;
        mem_serve(D7, 0);
        chk("t7_addr", LW'(addr_q[b]), LW'(32'h3100));

        // 3: icache kill in WAIT, response drained, pending dcache served next
        b = addr_q.size(); nic = ic_cnt; ndc = dc_cnt;
        fork
            ic_send(32'h4000);
            dc_send(32'h5000, 1'b0, '0);
            begin
                wait_req_hs();
                ic_kill_i = 1'b1; tick(); ic_kill_i = 1'b0;
                tick(); tick();
                give_resp(DEAD);
                mem_serve(D5, 0);
            end
        join
        chk("t3_ic_addr", LW'(addr_q[b]), LW'(32'h4000));
        chk("t3_dc_addr", LW'(addr_q[b+1]), LW'(32'h5000));
        chk("t3_ic_count", LW'(ic_cnt), LW'(nic));
        chk("t3_dc_data", dc_last, D5);
        chk("t3_dc_count", LW'(dc_cnt), LW'(ndc + 1));

        // 4: icache kill while the request is stalled
        b = addr_q.size(); nic = ic_cnt;
        mem_req_ready_i = 1'b0;
        ic_send(32'h6000);
        tick(); tick();
        ic_kill_i = 1'b1; tick(); ic_kill_i = 1'b0;
        tick(); tick();
        mem_req_ready_i = 1'b1;
        mem_serve(D6, 1);
        chk("t4_addr", LW'(addr_q[b]), LW'(32'h6000));
        chk("t4_ic_count", LW'(ic_cnt), LW'(nic));

        // 5: dcache response backpressure holds off the icache
        b = addr_q.size(); ndc = dc_cnt;
        dc_send(32'h7000, 1'b0, '0);
        dc_resp_ready_i = 1'b0;
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h8000;
        tick();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = D8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_mem_resp_ready_low", LW'(mem_resp_ready_o), LW'(0));
            chk("t5_ic_held", LW'(ic_req_ready_o), LW'(0));
            chk("t5_dc_valid", LW'(dc_resp_valid_o), LW'(1));
            @(posedge clk); #1;
        end
        dc_resp_ready_i = 1'b1;
        @(negedge clk);
        chk("t5_mem_resp_ready_high", LW'(mem_resp_ready_o), LW'(1));
        @(posedge clk); #1;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        ic_send(32'h8000);
        mem_serve(D9, 0);
        chk("t5_dc_count", LW'(dc_cnt), LW'(ndc + 1));
        chk("t5_dc_data", dc_last, D8);
        chk("t5_ic_addr", LW'(addr_q[b+1]), LW'(32'h8000));
        chk("t5_ic_data", ic_last, D9);

        // 6: reset in WAIT, then icache wins the first contention
        b = addr_q.size();
        ic_send(32'h9000);
        wait_req_hs();
        reset = 1'b1;
        ic_req_valid_i = 1'b1; ic_req_addr_i = 32'hA000;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 32'hB000; dc_req_we_i = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_mem_req_valid", LW'(mem_req_valid_o), LW'(0));
        chk("t6_mem_resp_ready", LW'(mem_resp_ready_o), LW'(0));
        chk("t6_ic_req_ready", LW'(ic_req_ready_o), LW'(0));
        chk("t6_dc_req_ready", LW'(dc_req_ready_o), LW'(0));
        chk("t6_ic_resp_valid", LW'(ic_resp_valid_o), LW'(0));
        chk("t6_dc_resp_valid", LW'(dc_resp_valid_o), LW'(0));
        chk("t6_mem_req_addr", LW'(mem_req_addr_o), LW'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            ic_send(32'hA000);
            dc_send(32'hB000, 1'b0, '0);
            begin mem_serve(DA, 0); mem_serve(DB, 0); end
        join
        chk("t6_first_after_reset", LW'(addr_q[b+1]), LW'(32'hA000));
        chk("t6_second_after_reset", LW'(addr_q[b+2]), LW'(32'hB000));
        chk("t6_ic_data", ic_last, DA);
        chk("t6_dc_data", dc_last, DB);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single memory/L2 port between the icache refill path (requester 0) and the dcache refill/writeback path (requester 1).
- One transaction outstanding at a time. Round-robin grant on contention. Grant is held until the matching response is consumed.
- An icache kill (branch mispredict, trap, mret) cancels a pending icache refill. Its in-flight response is drained and dropped, so a stale line never reaches the fetch path.

Parameters:
- ADDR_WIDTH, 32, request address width.
- LINE_WIDTH, 256, cache-line data width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ic_req_valid_i  in  1  icache refill request.
- ic_req_ready_o  out  1  request accepted by the arbiter.
- ic_req_addr_i  in  ADDR_WIDTH  line address.
- ic_kill_i  in  1  cancel the pending or in-flight icache refill.
- ic_resp_valid_o  out  1  refill data valid.
- ic_resp_ready_i  in  1  icache accepts the data.
- ic_resp_data_o  out  LINE_WIDTH  refill line.
- dc_req_valid_i  in  1  dcache request.
- dc_req_ready_o  out  1  accepted.
- dc_req_addr_i  in  ADDR_WIDTH  line address.
- dc_req_we_i  in  1  1 = writeback, 0 = refill.
- dc_req_wdata_i  in  LINE_WIDTH  writeback line.
- dc_resp_valid_o  out  1  response valid (write acks included).
- dc_resp_ready_i  in  1  dcache accepts.
- dc_resp_data_o  out  LINE_WIDTH  refill line.
- mem_req_valid_o  out  1  downstream request.
- mem_req_ready_i  in  1  downstream accepts.
- mem_req_addr_o  out  ADDR_WIDTH  address.
- mem_req_we_o  out  1  write enable.
- mem_req_wdata_o  out  LINE_WIDTH  write data.
- mem_resp_valid_i  in  1  downstream response.
- mem_resp_ready_o  out  1  arbiter accepts the response.
- mem_resp_data_i  in  LINE_WIDTH  response data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DRAIN.
- Registers: owner (0 = ic, 1 = dc), rr_last, and a latched copy of addr/we/wdata.
- Reset values:
  - state = IDLE, rr_last = 1 (icache wins the first tie).
  - All valid and ready outputs = 0.
  - Data and address outputs = 0.

IDLE:
- If exactly one requester is valid: grant it.
- If both are valid: grant the one that is not rr_last.
- On a grant:
  - Pulse the granted *_req_ready_o for one cycle.
  - Latch addr/we/wdata; set owner; set rr_last = owner.
  - Go to REQ next cycle.
- ic_req_valid_i together with ic_kill_i in the same cycle: the icache is not granted; the dcache may be.
- Combinational request-to-memory path: none. mem_req_* is driven only from the latched registers.

REQ:
- mem_req_valid_o = 1 with the latched fields, held stable until mem_req_ready_i.
- Handshake: go to WAIT, or to DRAIN if owner = ic and a kill was seen (see kill rules).
- Kill while in REQ: the request is still issued (memory protocol forbids retraction) and the cycle is marked killed.

WAIT:
- mem_resp_ready_o = owner's *_resp_ready_i.
- Owner's *_resp_valid_o = mem_resp_valid_i.
- *_resp_data_o = mem_resp_data_i.
- The non-owner's resp_valid stays 0.
- Response handshake: go to IDLE.
- ic_kill_i while owner = ic: go to DRAIN. ic_resp_valid_o is forced to 0 in that same cycle.

DRAIN:
- mem_resp_ready_o = 1; ic_resp_valid_o = 0.
- On mem_resp_valid_i the response is dropped and the state goes to IDLE.

Kill rules:
- ic_kill_i is ignored when owner = dc or the state is IDLE.
- dcache transactions are never cancelled.

Other rules:
- Response latency: one cycle minimum, from the memory response handshake to IDLE. The next grant can be given in that IDLE cycle.
- Reset mid-transaction: returns to IDLE. A downstream response still in flight is the memory controller's responsibility, since it is reset by the same reset.
- Fairness: after back-to-back contention, grants strictly alternate ic, dc, ic, …

Test Plan:
1. Simultaneous ic (0x1000) and dc (0x2000, we=0) requests after reset → mem sees 0x1000 first, then 0x2000. Each response is routed only to its owner. rr_last ends at 1.
2. dc writeback: addr 0x3000, we=1, wdata=0xA5…A5 → mem_req_we_o=1 with stable wdata until mem_req_ready_i. dc_resp_valid_o pulses once on the ack.
3. ic kill during WAIT, with the response arriving 3 cycles later (data 0xDEAD…) → ic_resp_valid_o stays 0 throughout. Arbiter returns to IDLE after the drained response, then serves a pending dc request.
4. ic kill asserted while REQ is stalled (mem_req_ready_i low for 5 cycles) → the request is still issued unchanged, its response is dropped, and there is no ic_resp_valid_o.
5. Owner backpressure: dc_resp_ready_i low for 4 cycles → mem_resp_ready_o stays low and the state stays WAIT. The ic request stays ungranted until the dc response handshake completes.
6. Reset asserted in WAIT → the next cycle has state IDLE and all valid/ready outputs 0. The first grant after reset goes to ic on contention.
